// File: rtl/ultrasonic_scheduler.sv
// Round-robin scheduler sharing one trigger/echo timing engine across NUM_SENSORS
// ultrasonic rangers; publishes tagged echo-width results and per-sensor near flags.
module ultrasonic_scheduler #(
    parameter int NUM_SENSORS  = 4,
    parameter int TRIG_CYCLES  = 10,
    parameter int WAIT_TIMEOUT = 32767,
    parameter int MAX_ECHO     = 32767,
    parameter int GUARD_CYCLES = 50
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [NUM_SENSORS-1:0] sensor_mask,
    input  logic [14:0]            threshold,
    input  logic [NUM_SENSORS-1:0] echo,
    output logic [NUM_SENSORS-1:0] trigger,
    output logic                   meas_valid,
    output logic [2:0]             meas_id,
    output logic [14:0]            meas_value,
    output logic                   meas_timeout,
    output logic [NUM_SENSORS-1:0] near,
    output logic                   busy
);
    typedef enum logic [2:0] {
        IDLE, SELECT, TRIGGER, WAIT_ECHO, MEASURE, REPORT, GUARD
    } state_t;

    localparam logic [14:0] TRIG_LAST  = 15'(TRIG_CYCLES - 1);
    localparam logic [14:0] WAIT_LAST  = 15'(WAIT_TIMEOUT - 1);
    localparam logic [14:0] ECHO_MAX   = 15'(MAX_ECHO);
    localparam logic [14:0] GUARD_LAST = 15'(GUARD_CYCLES - 1);
    localparam logic [2:0]  CUR_RESET  = 3'(NUM_SENSORS - 1);

    state_t                 state, state_nx;
    logic [2:0]             cur, cur_nx, next_sel;
    logic [14:0]            counter, counter_nx, result_value;
    logic [NUM_SENSORS-1:0] echo_meta, echo_s, near_nx;
    logic                   load_result, result_timeout, sel_found, echo_cur;
    int                     sel_idx;

    assign busy       = (state != IDLE);
    assign meas_valid = (state == REPORT);

    always_comb begin
        echo_cur = 1'b0;
        trigger  = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            if (cur == 3'(i)) begin
                echo_cur   = echo_s[i];
                trigger[i] = (state == TRIGGER);
            end
        end
    end

    // Next enabled sensor after cur, wrapping; lands back on cur when it is the only one.
    always_comb begin
        sel_found = 1'b0;
        next_sel  = cur;
        sel_idx   = 0;
        for (int k = 1; k <= NUM_SENSORS; k++) begin
            sel_idx = int'(cur) + k;
            if (sel_idx >= NUM_SENSORS) sel_idx = sel_idx - NUM_SENSORS;
            for (int j = 0; j < NUM_SENSORS; j++) begin
                if (!sel_found && j == sel_idx && sensor_mask[j]) begin
                    sel_found = 1'b1;
                    next_sel  = 3'(j);
                end
            end
        end
    end

    always_comb begin
        state_nx       = state;
        cur_nx         = cur;
        counter_nx     = counter;
        load_result    = 1'b0;
        result_value   = counter;
        result_timeout = 1'b0;
        case (state)
            IDLE: begin
                if (enable && |sensor_mask) state_nx = SELECT;
            end
            SELECT: begin
                counter_nx = '0;
                if (sel_found) begin
                    cur_nx   = next_sel;
                    state_nx = TRIGGER;
                end else begin
                    state_nx = IDLE;
                end
            end
            TRIGGER: begin
                if (counter == TRIG_LAST) begin
                    state_nx   = WAIT_ECHO;
                    counter_nx = '0;
                end else begin
                    counter_nx = counter + 15'd1;
                end
            end
            WAIT_ECHO: begin
                if (echo_cur) begin
                    state_nx   = MEASURE;
                    counter_nx = 15'd1;
                end else if (counter == WAIT_LAST) begin
                    state_nx       = REPORT;
                    load_result    = 1'b1;
                    result_value   = 15'h7FFF;
                    result_timeout = 1'b1;
                end else begin
                    counter_nx = counter + 15'd1;
                end
            end
            MEASURE: begin
                if (!echo_cur) begin
                    state_nx    = REPORT;
                    load_result = 1'b1;
                end else if (counter == ECHO_MAX) begin
                    state_nx       = REPORT;
                    load_result    = 1'b1;
                    result_value   = ECHO_MAX;
                    result_timeout = 1'b1;
                end else begin
                    counter_nx = counter + 15'd1;
                end
            end
            REPORT: begin
                state_nx   = GUARD;
                counter_nx = '0;
            end
            GUARD: begin
                if (counter == GUARD_LAST) begin
                    state_nx   = enable ? SELECT : IDLE;
                    counter_nx = '0;
                end else begin
                    counter_nx = counter + 15'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Deselected sensors lose their near flag immediately, even mid-measurement.
    always_comb begin
        near_nx = near;
        if (state == REPORT) begin
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (cur == 3'(i)) near_nx[i] = !meas_timeout && (meas_value < threshold);
            end
        end
        near_nx = near_nx & sensor_mask;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cur          <= CUR_RESET;
            counter      <= '0;
            echo_meta    <= '0;
            echo_s       <= '0;
            near         <= '0;
            meas_id      <= '0;
            meas_value   <= '0;
            meas_timeout <= 1'b0;
        end else begin
            state     <= state_nx;
            cur       <= cur_nx;
            counter   <= counter_nx;
            echo_meta <= echo;
            echo_s    <= echo_meta;
            near      <= near_nx;
            if (load_result) begin
                meas_id      <= cur;
                meas_value   <= result_value;
                meas_timeout <= result_timeout;
            end
        end
    end
endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Bench for ultrasonic_scheduler: per-sensor echo responders react to trigger falls, and a
// reference model predicts rotation order, results, report spacing and near flags.
module tb_ultrasonic_scheduler;
    localparam int NS     = 4;
    localparam int TRIG   = 10;
    localparam int WTO    = 400;
    localparam int MAXE   = 32767;
    localparam int GUARD  = 50;
    localparam int NORMAL = 0;
    localparam int SILENT = 1;
    localparam int STUCK  = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          enable;
    logic [NS-1:0] sensor_mask;
    logic [14:0]   threshold;
    logic [NS-1:0] echo;
    logic [NS-1:0] trigger;
    logic          meas_valid;
    logic [2:0]    meas_id;
    logic [14:0]   meas_value;
    logic          meas_timeout;
    logic [NS-1:0] near;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int nedge = 0;
    int mode [NS];
    int dly [NS];
    int wid [NS];
    int rise_at [NS];
    int fall_at [NS];
    int run [NS];
    logic [NS-1:0] trig_prev = '0;

    int            exp_cur;
    logic [NS-1:0] near_m;
    int            prev_cyc;
    bit            prev_valid;

    ultrasonic_scheduler #(
        .NUM_SENSORS(NS), .TRIG_CYCLES(TRIG), .WAIT_TIMEOUT(WTO),
        .MAX_ECHO(MAXE), .GUARD_CYCLES(GUARD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sensor_mask(sensor_mask),
        .threshold(threshold), .echo(echo), .trigger(trigger), .meas_valid(meas_valid),
        .meas_id(meas_id), .meas_value(meas_value), .meas_timeout(meas_timeout),
        .near(near), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Echo rises d negedges after the trigger fall and stays high for w negedges.
    always @(negedge clk) begin
        nedge = nedge + 1;
        for (int i = 0; i < NS; i++) begin
            if (trig_prev[i] && !trigger[i] && rst_n === 1'b1) begin
                rise_at[i] = nedge + dly[i];
                fall_at[i] = rise_at[i] + wid[i];
            end
            trig_prev[i] = trigger[i];
            if (mode[i] == STUCK)       echo[i] = 1'b1;
            else if (mode[i] == SILENT) echo[i] = 1'b0;
            else                        echo[i] = (nedge >= rise_at[i]) && (nedge < fall_at[i]);
        end
    end

    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            for (int i = 0; i < NS; i++) run[i] = 0;
        end else begin
            if (trigger !== '0) begin
                checkOutput("trigger_onehot", 32'($countones(trigger) <= 1), 32'd1);
                checkOutput("trigger_in_mask", 32'(trigger & ~sensor_mask), 32'd0);
            end
            for (int i = 0; i < NS; i++) begin
                if (trigger[i] === 1'b1) run[i]++;
                else if (run[i] != 0) begin
                    checkOutput("trigger_width", 32'(run[i]), 32'(TRIG));
                    run[i] = 0;
                end
            end
        end
    end

    function automatic int nextId(input int from, input logic [NS-1:0] mask);
        for (int k = 1; k <= NS; k++) if (mask[(from + k) % NS]) return (from + k) % NS;
        return from;
    endfunction

    task automatic applyStimulus(input bit en, input logic [NS-1:0] mask, input logic [14:0] thr);
        @(negedge clk);
        enable      = en;
        sensor_mask = mask;
        threshold   = thr;
    endtask

    task automatic setSensor(input int i, input int m, input int d, input int w);
        mode[i] = m;
        dly[i]  = d;
        wid[i]  = w;
    endtask

    task automatic randomizeSensor(input int i);
        setSensor(i, ($urandom_range(0, 4) == 0) ? SILENT : NORMAL,
                  int'($urandom_range(0, 60)), int'($urandom_range(1, 800)));
    endtask

    task automatic waitIdle(input int maxc);
        bit idle = 0;
        for (int n = 0; n < maxc && !idle; n++) begin
            @(negedge clk);
            if (busy === 1'b0) idle = 1;
        end
        checkOutput("reaches_idle", 32'(idle), 32'd1);
        prev_valid = 0;
    endtask

    task automatic waitTrigger(input string tag, input bit want_high, input int maxc);
        bit seen = 0;
        for (int n = 0; n < maxc && !seen; n++) begin
            @(negedge clk);
            if ((trigger !== '0) == want_high) seen = 1;
        end
        checkOutput(tag, 32'(seen), 32'd1);
    endtask

    task automatic expectReport(input int maxc);
        bit          got = 0;
        int          id;
        logic [14:0] ev;
        bit          eto;
        for (int n = 0; n < maxc && !got; n++) begin
            @(negedge clk);
            if (meas_valid === 1'b1) got = 1;
        end
        checkOutput("report_arrives", 32'(got), 32'd1);
        if (!got) return;
        id = nextId(exp_cur, sensor_mask);
        if (mode[id] == NORMAL) begin
            ev  = 15'(wid[id]);
            eto = 0;
        end else begin
            ev  = 15'h7FFF;
            eto = 1;
        end
        checkOutput("meas_id", 32'(meas_id), 32'(id));
        checkOutput("meas_value", 32'(meas_value), 32'(ev));
        checkOutput("meas_timeout", 32'(meas_timeout), 32'(eto));
        checkOutput("busy_in_report", 32'(busy), 32'd1);
        // Wait phase is the responder delay plus two synchronizer stages plus one detect cycle.
        if (prev_valid && mode[id] == NORMAL)
            checkOutput("report_gap", 32'(cyc - prev_cyc),
                        32'(1 + TRIG + (dly[id] + 3) + wid[id] + 1 + GUARD));
        prev_cyc   = cyc;
        prev_valid = 1;
        exp_cur    = id;
        near_m[id] = !eto && (ev < threshold);
        @(negedge clk);
        near_m = near_m & sensor_mask;
        checkOutput("near", 32'(near), 32'(near_m));
        checkOutput("strobe_one_cycle", 32'(meas_valid), 32'd0);
        checkOutput("meas_id_held", 32'(meas_id), 32'(id));
    endtask

    initial begin
        int n;
        rst_n       = 1'b0;
        enable      = 1'b0;
        sensor_mask = '0;
        threshold   = '0;
        exp_cur     = NS - 1;
        near_m      = '0;
        prev_valid  = 0;
        for (int i = 0; i < NS; i++) setSensor(i, NORMAL, 30, 200);
        repeat (3) @(negedge clk);
        checkOutput("reset_trigger", 32'(trigger), 32'd0);
        checkOutput("reset_near", 32'(near), 32'd0);
        checkOutput("reset_valid", 32'(meas_valid), 32'd0);
        checkOutput("reset_id", 32'(meas_id), 32'd0);
        checkOutput("reset_value", 32'(meas_value), 32'd0);
        checkOutput("reset_timeout", 32'(meas_timeout), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;

        $display("[TB] full rotation, fixed 200-cycle echoes");
        applyStimulus(1'b1, 4'b1111, 15'd300);
        repeat (6) expectReport(1500);

        $display("[TB] sparse mask 0101 with random echoes");
        setSensor(0, NORMAL, int'($urandom_range(0, 60)), int'($urandom_range(1, 800)));
        setSensor(2, NORMAL, int'($urandom_range(0, 60)), int'($urandom_range(1, 800)));
        applyStimulus(1'b1, 4'b0101, 15'($urandom_range(100, 700)));
        for (int r = 0; r < 6; r++) begin
            expectReport(2000);
            setSensor(exp_cur, NORMAL, int'($urandom_range(0, 60)), int'($urandom_range(1, 800)));
        end

        $display("[TB] sensor 1 silent");
        for (int i = 0; i < NS; i++)
            setSensor(i, (i == 1) ? SILENT : NORMAL, int'($urandom_range(0, 60)),
                      int'($urandom_range(1, 800)));
        applyStimulus(1'b1, 4'b1111, 15'($urandom_range(100, 900)));
        repeat (5) expectReport(2000);

        $display("[TB] threshold boundary on sensor 3");
        setSensor(3, NORMAL, 20, 499);
        applyStimulus(1'b1, 4'b1000, 15'd500);
        expectReport(2000);
        setSensor(3, NORMAL, 20, 500);
        expectReport(2000);
        setSensor(3, NORMAL, 20, 1);
        expectReport(2000);
        applyStimulus(1'b0, 4'b1000, 15'd500);
        waitIdle(200);

        $display("[TB] enable dropped mid-measure");
        setSensor(0, NORMAL, 10, 300);
        applyStimulus(1'b1, 4'b0001, 15'd1000);
        waitTrigger("trigger_rises", 1'b1, 100);
        waitTrigger("trigger_falls", 1'b0, 100);
        repeat (100) @(negedge clk);
        applyStimulus(1'b0, 4'b0001, 15'd1000);
        expectReport(1000);
        n = 1;
        while (busy === 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("guard_then_idle", 32'(n), 32'(GUARD + 1));
        repeat (20) @(negedge clk);
        checkOutput("idle_no_trigger", 32'(trigger), 32'd0);
        checkOutput("idle_not_busy", 32'(busy), 32'd0);
        prev_valid = 0;

        $display("[TB] reset during trigger");
        applyStimulus(1'b1, 4'b1111, 15'd1000);
        waitTrigger("trigger_before_reset", 1'b1, 100);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_trigger", 32'(trigger), 32'd0);
        checkOutput("rst_near", 32'(near), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_value", 32'(meas_value), 32'd0);
        checkOutput("rst_valid", 32'(meas_valid), 32'd0);
        enable = 1'b0;
        @(negedge clk);
        rst_n      = 1'b1;
        exp_cur    = NS - 1;
        near_m     = '0;
        prev_valid = 0;

        $display("[TB] stuck echo, then mask cleared in guard");
        setSensor(0, NORMAL, 5, 50);
        setSensor(2, STUCK, 0, 0);
        applyStimulus(1'b1, 4'b0101, 15'd1000);
        expectReport(1000);
        expectReport(40000);
        applyStimulus(1'b1, 4'b0000, 15'd1000);
        @(negedge clk);
        near_m = near_m & sensor_mask;
        checkOutput("near_cleared_by_mask", 32'(near), 32'(near_m));
        waitIdle(200);
        setSensor(2, NORMAL, 10, 100);

        $display("[TB] random rotation");
        for (int i = 0; i < NS; i++) randomizeSensor(i);
        applyStimulus(1'b1, 4'($urandom_range(1, 15)), 15'($urandom_range(0, 1000)));
        for (int r = 0; r < 12; r++) begin
            expectReport(3000);
            randomizeSensor(exp_cur);
            if (r % 4 == 3) applyStimulus(1'b1, 4'($urandom_range(1, 15)), threshold);
        end
        applyStimulus(1'b0, sensor_mask, threshold);
        waitIdle(3000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
